// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int KEY_W = 4;

   localparam logic [ROWS-1:0] ROWS_IDLE = 4'hF;

   typedef struct packed {
      logic       single;
      logic [1:0] idx;
   } row_hit_t;

   // Active-low rows: single is set only when exactly one row is pulled low.
   function automatic row_hit_t onehot_low_idx(input logic [ROWS-1:0] rows);
      row_hit_t hit;
      hit = '0;
      case (rows)
         4'b1110: begin hit.single = 1'b1; hit.idx = 2'd0; end
         4'b1101: begin hit.single = 1'b1; hit.idx = 2'd1; end
         4'b1011: begin hit.single = 1'b1; hit.idx = 2'd2; end
         4'b0111: begin hit.single = 1'b1; hit.idx = 2'd3; end
         default: hit = '0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/keypad_slot_timer.sv
// Column slot divider: one tick every SCAN_DIV clock cycles.
module keypad_slot_timer #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int W = $clog2(SCAN_DIV);
   localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

   logic [W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, one strobe per press.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid every REPEAT_SLOTS slots while held.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SLOTS = 4,
   parameter int REPEAT_SLOTS   = 200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ROWS-1:0]  row_n,
   output logic [COLS-1:0]  col_n,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held
);

   if (SCAN_DIV < 4) begin : g_bad_div
      $error("SCAN_DIV must be >= 4");
   end
   if (DEBOUNCE_SLOTS < 1) begin : g_bad_deb
      $error("DEBOUNCE_SLOTS must be >= 1");
   end
   if (REPEAT_SLOTS < 1) begin : g_bad_rep
      $error("REPEAT_SLOTS must be >= 1");
   end

   localparam int DW = $clog2(DEBOUNCE_SLOTS + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SLOTS);

   logic             tick;
   logic [ROWS-1:0]  sync1;
   logic [ROWS-1:0]  rows_s;
   logic [ROWS-1:0]  pattern;
   row_hit_t         hit;
   state_t           state;
   state_t           state_next;
   logic [1:0]       col;
   logic [1:0]       col_next;
   logic [1:0]       cand_row;
   logic [1:0]       row_next;
   logic [DW-1:0]    deb_cnt;
   logic [DW-1:0]    deb_next;
   logic [DW-1:0]    rel_cnt;
   logic [DW-1:0]    rel_next;
   logic [KEY_W-1:0] code_next;
   logic             valid_next;

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_SLOTS + 1);
   localparam logic [RW-1:0] RLAST = RW'(REPEAT_SLOTS - 1);
   logic [RW-1:0] rep_cnt;
   logic [RW-1:0] rep_next;
`endif

   keypad_slot_timer #(
      .SCAN_DIV (SCAN_DIV)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= ROWS_IDLE;
         rows_s <= ROWS_IDLE;
      end else begin
         sync1  <= row_n;
         rows_s <= sync1;
      end
   end

   assign col_n    = ~(4'b0001 << col);
   assign pattern  = ~(4'b0001 << cand_row);
   assign hit      = onehot_low_idx(rows_s);
   assign key_held = (state == HELD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         col       <= '0;
         cand_row  <= '0;
         deb_cnt   <= '0;
         rel_cnt   <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         state     <= state_next;
         col       <= col_next;
         cand_row  <= row_next;
         deb_cnt   <= deb_next;
         rel_cnt   <= rel_next;
         key_code  <= code_next;
         key_valid <= valid_next;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= rep_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      col_next   = col;
      row_next   = cand_row;
      deb_next   = deb_cnt;
      rel_next   = rel_cnt;
      code_next  = key_code;
      valid_next = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_next   = rep_cnt;
`endif
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (hit.single) begin
                  row_next   = hit.idx;
                  deb_next   = '0;
                  state_next = DEBOUNCE;
               end else begin
                  col_next = col + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (rows_s == pattern) begin
                  if (deb_cnt != DMAX) deb_next = deb_cnt + 1'b1;
                  if (deb_next == DMAX) begin
                     code_next  = {cand_row, col};
                     valid_next = 1'b1;
                     rel_next   = '0;
                     deb_next   = '0;
                     state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_next   = '0;
`endif
                  end
               end else begin
                  state_next = SCAN;
                  col_next   = col + 1'b1;
               end
            end
            HELD: begin
               if (rows_s == ROWS_IDLE) begin
                  if (rel_cnt != DMAX) rel_next = rel_cnt + 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rep_next = '0;
`endif
                  if (rel_next == DMAX) begin
                     rel_next   = '0;
                     state_next = SCAN;
                     col_next   = col + 1'b1;
                  end
               end else begin
                  rel_next = '0;
`ifdef KEYPAD_REPEAT_EN
                  // Repeat phase restarts from acceptance or any aborted release.
                  if (rep_cnt >= RLAST) begin
                     rep_next   = '0;
                     valid_next = 1'b1;
                  end else begin
                     rep_next = rep_cnt + 1'b1;
                  end
`endif
               end
            end
            default: begin
               state_next = SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad model.
module tb_keypad_scanner;

   localparam int DIV = 4;
   localparam int DEB = 3;
   localparam int REP = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [3:0] code_q[$];
   int         time_q[$];

   int         base;
   int         c0;
   int         t0;
   int         n;
   int         lat;
   logic [3:0] exp_col;
   logic [3:0] prev_col;
   logic [3:0] last_code;
   int         k;
   int         k2;
   int         hold;
   bit         ghost;

   keypad_scanner #(
      .SCAN_DIV       (DIV),
      .DEBOUNCE_SLOTS (DEB),
      .REPEAT_SLOTS   (REP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         code_q.push_back(key_code);
         time_q.push_back(cyc);
      end
   end

   // Passive matrix: a pressed key shorts its row to its column when driven low.
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && (col_n[c] === 1'b0)) row_n[r] = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic align_col(input logic [3:0] target);
      int w = 0;
      while (col_n == target && w < 64) begin @(negedge clk); w++; end
      while (col_n != target && w < 64) begin @(negedge clk); w++; end
      chk("align_col", col_n, target);
   endtask

   task automatic wait_pulse(input int b, input int budget, input string tag);
      int w = 0;
      while (code_q.size() <= b && w < budget) begin @(negedge clk); w++; end
      chk(tag, code_q.size() > b, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      keys  = '0;
      repeat (3) @(negedge clk);
      chk("rst_col_n", col_n, 4'b1110);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      chk("rst_code", key_code, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle scan: one column step every DIV cycles, rotating 0->1->2->3->0.
      align_col(4'b1101);
      exp_col = 4'b1101;
      for (int i = 0; i < 8; i++) begin
         repeat (DIV - 1) @(negedge clk);
         chk("col_stable", col_n, exp_col);
         @(negedge clk);
         exp_col = {exp_col[2:0], exp_col[3]};
         chk("col_step", col_n, exp_col);
      end

      // Clean press of row 2, col 1.
      align_col(4'b1110);
      base = code_q.size();
      keys = 16'h0200;
      align_col(4'b1101);
      c0 = cyc;
      wait_pulse(base, 100, "press_seen");
      lat = (code_q.size() > base) ? (time_q[base] - c0) : -1;
      chk("press_latency", (lat >= DEB*DIV + 1 && lat <= DEB*DIV + 1 + 2*DIV), 1);
      chk("press_code_q", (code_q.size() > base) ? code_q[base] : 4'hx, 9);
      repeat (40) @(negedge clk);
      chk("held_pressed", key_held, 1);
      keys = '0;
      @(negedge clk);
      chk("held_release_start", key_held, 1);
      repeat (20) @(negedge clk);
      chk("held_released", key_held, 0);
      n = code_q.size() - base;
`ifdef KEYPAD_REPEAT_EN
      chk("press_pulses", n >= 1, 1);
`else
      chk("press_pulses", n, 1);
`endif
      chk("press_code_out", key_code, 9);
      prev_col = col_n;
      n = 0;
      while (col_n == prev_col && n < 8) begin @(negedge clk); n++; end
      chk("scan_resumed", col_n != prev_col, 1);

      // Bounce on row 0, col 2: one matching tick then a mismatch, three times.
      base = code_q.size();
      for (int i = 0; i < 3; i++) begin
         align_col(4'b1011);
         keys = 16'h0004;
         repeat (DIV) @(negedge clk);
         chk("bounce_col_held", col_n, 4'b1011);
         keys = '0;
         repeat (DIV) @(negedge clk);
         chk("bounce_col_adv", col_n, 4'b0111);
      end
      repeat (20) @(negedge clk);
      chk("bounce_no_valid", code_q.size() - base, 0);
      chk("bounce_not_held", key_held, 0);

      // Ghost: two rows low on column 0.
      base = code_q.size();
      align_col(4'b1110);
      keys = 16'h1100;
      repeat (DIV) @(negedge clk);
      chk("ghost_col_adv", col_n, 4'b1101);
      keys = '0;
      repeat (20) @(negedge clk);
      chk("ghost_no_valid", code_q.size() - base, 0);

      // Reset after the second matching debounce tick.
      base = code_q.size();
      align_col(4'b0111);
      keys = 16'h0080;
      repeat (3*DIV) @(negedge clk);
      chk("mid_deb_col_held", col_n, 4'b0111);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_col_n", col_n, 4'b1110);
      chk("mid_rst_code", key_code, 0);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_held", key_held, 0);
      @(negedge clk);
      keys = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_rst_no_valid", code_q.size() - base, 0);

      // Long hold of key 15.
      base = code_q.size();
      keys = 16'h8000;
      wait_pulse(base, 100, "k15_seen");
      repeat (60*DIV) @(negedge clk);
      keys = '0;
      repeat (40) @(negedge clk);
      n = code_q.size() - base;
      for (int i = 0; i < n && i < 20; i++)
         chk("k15_code", code_q[base+i], 15);
`ifdef KEYPAD_REPEAT_EN
      chk("k15_pulse_count", (n >= 12 && n <= 13), 1);
      for (int i = 1; i < n && i < 20; i++)
         chk("k15_interval", time_q[base+i] - time_q[base+i-1], REP*DIV);
`else
      chk("k15_pulse_count", n, 1);
`endif
      chk("k15_code_out", key_code, 15);
      last_code = 4'd15;

      // Random presses, some as same-column ghosts.
      for (int it = 0; it < 8; it++) begin
         base  = code_q.size();
         k     = $urandom_range(0, 15);
         ghost = ($urandom_range(0, 3) == 0);
         k2    = (((k / 4) + 1 + $urandom_range(0, 2)) % 4) * 4 + (k % 4);
         hold  = $urandom_range(80, 160);
         keys  = 16'(1) << k;
         if (ghost) keys = keys | (16'(1) << k2);
         repeat (hold) @(negedge clk);
         keys = '0;
         repeat (40) @(negedge clk);
         n = code_q.size() - base;
         if (ghost) begin
            chk("rnd_ghost_pulses", n, 0);
         end else begin
`ifdef KEYPAD_REPEAT_EN
            chk("rnd_pulses", n >= 1, 1);
`else
            chk("rnd_pulses", n, 1);
`endif
            chk("rnd_code_q", (n > 0) ? code_q[base] : 4'hx, k);
            last_code = 4'(k);
         end
         chk("rnd_code_out", key_code, last_code);
         chk("rnd_not_held", key_held, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
